// File: rtl/exec_step_ctrl.sv
// Core clock-enable sequencer: free-run / single-step / halt with PC breakpoint and retired-cycle counter.
// Latency: cpu_en follows clk_select by 3 cycles; a clean step press yields one enabled cycle DEBOUNCE_CYCLES+2 cycles later.
// No backpressure: the core simply stalls on every cycle where cpu_en is low.
module exec_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32,
  parameter int PC_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_select,
  input  logic             clk_step,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             halt_cause,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Synchronizer and edge-detect storage
  logic sel_q1, sel_s, sel_s_d;
  logic step_q1, step_s, step_f, step_f_d;
  logic [DB_W-1:0] db_cnt;

  // FSM and breakpoint storage
  state_t cur_st, nxt_st;
  logic   nxt_cause;
  logic   bp_armed;

  logic step_pulse;
  logic sel_rise;
  logic bp_hit;
  logic enter_exec;

  // Two-flop synchronizers for both board inputs, plus delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q1   <= 1'b0;
      sel_s    <= 1'b0;
      sel_s_d  <= 1'b0;
      step_q1  <= 1'b0;
      step_s   <= 1'b0;
      step_f_d <= 1'b0;
    end else begin
      sel_q1   <= clk_select;
      sel_s    <= sel_q1;
      sel_s_d  <= sel_s;
      step_q1  <= clk_step;
      step_s   <= step_q1;
      step_f_d <= step_f;
    end
  end

  // Debounce: filtered level only follows the synchronized button after a full run of differing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      step_f <= 1'b0;
      db_cnt <= '0;
    end else if (step_s != step_f) begin
      if (db_cnt == DB_LAST) begin
        step_f <= step_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign step_pulse = step_f & ~step_f_d;
  assign sel_rise   = sel_s & ~sel_s_d;

  // Enable comes straight from the state register so it cannot glitch
  assign cpu_en = (cur_st == RUN) | (cur_st == STEP);
  assign halted = (cur_st == HALT);
  assign state  = cur_st;
  assign bp_hit = bp_en & bp_armed & (pc == bp_addr) & cpu_en;

  // Next-state decode; halt_req outranks a breakpoint hit in the same cycle
  always_comb begin
    nxt_st    = cur_st;
    nxt_cause = 1'b0;
    case (cur_st)
      IDLE: begin
        if (sel_s)           nxt_st = RUN;
        else if (step_pulse) nxt_st = STEP;
      end
      RUN: begin
        if (halt_req) begin
          nxt_st    = HALT;
          nxt_cause = 1'b0;
        end else if (bp_hit) begin
          nxt_st    = HALT;
          nxt_cause = 1'b1;
        end else if (!sel_s) begin
          nxt_st = IDLE;
        end
      end
      STEP: begin
        if (halt_req) begin
          nxt_st    = HALT;
          nxt_cause = 1'b0;
        end else if (bp_hit) begin
          nxt_st    = HALT;
          nxt_cause = 1'b1;
        end else begin
          nxt_st = IDLE;
        end
      end
      HALT: begin
        if (sel_rise)                 nxt_st = RUN;
        else if (step_pulse && !sel_s) nxt_st = STEP;
      end
      default: nxt_st = IDLE;
    endcase
  end

  // Entering an executing state disarms the breakpoint so a resumed PC is not re-trapped
  assign enter_exec = ((nxt_st == RUN) && (cur_st != RUN)) || (nxt_st == STEP);

  // State register and halt cause, captured only on entry into HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st     <= IDLE;
      halt_cause <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if ((nxt_st == HALT) && (cur_st != HALT)) halt_cause <= nxt_cause;
    end
  end

  // Breakpoint arming: cleared on entry to RUN/STEP, set once one enabled cycle has retired
  always_ff @(posedge clk) begin
    if (rst)             bp_armed <= 1'b0;
    else if (enter_exec) bp_armed <= 1'b0;
    else if (cpu_en)     bp_armed <= 1'b1;
  end

  // Retired-cycle counter, wraps naturally at all-ones
  always_ff @(posedge clk) begin
    if (rst)         cycle_count <= '0;
    else if (cpu_en) cycle_count <= cycle_count + CNT_ONE;
  end

endmodule

// File: doc/exec_step_ctrl.md
# exec_step_ctrl

Execution controller that sequences the ARM processor core's clock enable. It selects between free-run and single-step modes from the board-level `clk_select` switch and `clk_step` button, and halts on a processor halt request or a PC breakpoint. It exposes a retired-cycle counter for debug. It sits between the board inputs and `procesadorArm`; the core advances only on cycles where `cpu_en` is high.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before the filtered step level changes; must be ≥ 1.
- `CNT_W`, default 32: width of `cycle_count`.
- `PC_W`, default 32: width of `pc` and `bp_addr`.

Ports:
- `clk`  in  1: single system clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `clk_select`  in  1: mode switch, asynchronous; 1 = free-run, 0 = single-step.
- `clk_step`  in  1: step button, asynchronous and bouncy; active-high.
- `halt_req`  in  1: halt request from the core; sampled only on cycles where `cpu_en` = 1.
- `pc`  in  PC_W: current core PC.
- `bp_en`  in  1: breakpoint enable.
- `bp_addr`  in  PC_W: breakpoint address.
- `cpu_en`  out  1: core clock enable.
- `state`  out  2: FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALT.
- `halted`  out  1: high while in HALT.
- `halt_cause`  out  1: 0 = `halt_req`, 1 = breakpoint; valid while `halted` = 1.
- `cycle_count`  out  CNT_W: number of cycles with `cpu_en` = 1.

## Operation

Input conditioning:
- `clk_select` and `clk_step` each pass through a 2-flop synchronizer, giving `sel_s` and `step_s`.
- Debounce: a counter increments on every cycle where `step_s` differs from the filtered level `step_f`, and clears to 0 when they match.
- After `DEBOUNCE_CYCLES` consecutive differing cycles, `step_f` takes the value of `step_s` and the counter clears.
- `step_pulse` = `step_f` & ~`step_f_d`: one cycle wide, on the rising edge only.
- `sel_rise` = `sel_s` & ~`sel_s_d`.

FSM (`state` is registered):
- IDLE:
  - `sel_s` = 1 → RUN.
  - Otherwise, `step_pulse` → STEP.
- RUN:
  - `halt_req` → HALT with cause 0.
  - Else breakpoint hit → HALT with cause 1.
  - Else `sel_s` = 0 → IDLE.
  - Else stay in RUN.
- STEP:
  - `halt_req` → HALT with cause 0.
  - Else breakpoint hit → HALT with cause 1.
  - Else → IDLE.
  - STEP always lasts exactly one cycle.
- HALT:
  - `sel_rise` → RUN.
  - Else `step_pulse` with `sel_s` = 0 → STEP.
  - Else stay in HALT.

Outputs and breakpoint logic:
- `cpu_en` = (state == RUN) | (state == STEP). It is decoded from the registered state only and is glitch-free.
- Breakpoint hit = `bp_en` & `bp_armed` & (`pc` == `bp_addr`) & `cpu_en`.
- `bp_armed` clears on every transition into RUN or STEP, and sets after the first `cpu_en` cycle. As a result, resuming from a breakpoint executes the breakpointed instruction instead of re-halting.
- `halt_req` has priority over a breakpoint in the same cycle, so `halt_cause` = 0.
- `cycle_count` increments on every cycle where `cpu_en` = 1, wraps from all-ones to 0, and clears only on `rst`.

## Timing

- Reset values: `state` = IDLE, `cpu_en` = 0, `halted` = 0, `halt_cause` = 0, `cycle_count` = 0, `bp_armed` = 0, all synchronizer flops and `step_f` = 0, debounce counter = 0.
- Step latency, with `clk_step` stable high before edge N: `step_f` rises at edge N+1+D (D = `DEBOUNCE_CYCLES`), state = STEP after edge N+2+D, and `cpu_en` is high for exactly that one cycle.
- A button held longer than one cycle gives exactly one step. A bounce shorter than D cycles gives no step.
- Free-run: `cpu_en` rises 3 cycles after `clk_select` rises (2 sync stages plus the state register). It falls 3 cycles after `clk_select` falls.
- Halt: if `halt_req` or a breakpoint hit is present during an enabled cycle ending at edge M, `cpu_en` = 0 and `halted` = 1 from edge M. The instruction in that cycle has executed.
- `rst` asserted in any state forces the reset values at the next edge, overriding all other inputs.
- If the button is held through reset, one step is generated D+2 cycles after `rst` deasserts.
- `step_pulse` in RUN is ignored. `sel_s` = 1 in IDLE takes priority over `step_pulse`.

## Test plan

- Reset mid-RUN (`cycle_count` = 57): assert `rst` for 1 cycle → next edge `state` = 0, `cpu_en` = 0, `cycle_count` = 0. Nothing changes until `clk_select` or `clk_step` is applied.
- D = 4, `clk_select` = 0, `clk_step` high for 40 cycles with a 2-cycle bounce at the start → exactly one `cpu_en` cycle, at edge N+6, and `cycle_count` = 1.
- `clk_select` 0→1 for 100 cycles then 1→0 → `cpu_en` high for exactly 100 consecutive cycles, starting 3 cycles after the rise, and `cycle_count` = 100.
- RUN with `bp_en` = 1, `bp_addr` = 0x20, `pc` reaching 0x20 → HALT, `halt_cause` = 1, `cpu_en` low from the next edge. A following `step_pulse` executes one cycle at pc 0x20 with no re-halt, then returns to IDLE.
- RUN, `halt_req` and breakpoint hit in the same cycle → HALT with `halt_cause` = 0. Then toggle `clk_select` 1→0→1 → RUN resumes.
- CNT_W = 4, free-run for 17 cycles → `cycle_count` wraps 15 → 0 and reads 1.
